// File: rtl/vram_blit_pkg.sv
// Shared constants, source encodings and FSM states for the VRAM blitter.
// Colour keying is compiled in only when VRAM_BLIT_COLORKEY_EN is defined.
package vram_blit_pkg;
   localparam int FB_W_DEF = 320;
   localparam int FB_H_DEF = 240;
   localparam int TILE_DIM = 32;

   localparam logic [11:0] COLOR_KEY = 12'hF0F;

   localparam logic [1:0] SRC_BG   = 2'd0;
   localparam logic [1:0] SRC_CHR  = 2'd1;
   localparam logic [1:0] SRC_WALL = 2'd2;
   localparam logic [1:0] SRC_FILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } blit_state_e;
endpackage

// File: rtl/blit_addr_gen.sv
// Tile pixel counter and framebuffer address/bounds generation.
// Row pitch multiply is shift-add when the pitch is 320 (256 + 64).
module blit_addr_gen
   import vram_blit_pkg::*;
#(
   parameter int FB_W = FB_W_DEF,
   parameter int FB_H = FB_H_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [8:0]  x,
   input  logic [7:0]  y,
   output logic [9:0]  idx,
   output logic        last,
   output logic        in_bounds,
   output logic [17:0] pix_addr
);
   logic [9:0]  idx_q, idx_d;
   logic [4:0]  tx, ty;
   logic [9:0]  px;
   logic [8:0]  py;
   logic [17:0] row_base;

   always_comb begin
      idx_d = idx_q;
      if (clr)
         idx_d = '0;
      else if (en)
         idx_d = idx_q + 10'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         idx_q <= '0;
      else
         idx_q <= idx_d;
   end

   assign idx  = idx_q;
   assign last = (idx_q == 10'(TILE_DIM * TILE_DIM - 1));
   assign tx   = idx_q[4:0];
   assign ty   = idx_q[9:5];
   assign px   = 10'(x) + 10'(tx);
   assign py   = 9'(y) + 9'(ty);

   assign in_bounds = (px < 10'(FB_W)) && (py < 9'(FB_H));

   if (FB_W == 320) begin : g_shift
      assign row_base = (18'(py) << 8) + (18'(py) << 6);
   end else begin : g_mul
      assign row_base = 18'(py) * 18'(FB_W);
   end

   assign pix_addr = row_base + 18'(px);
endmodule

// File: rtl/vram_blitter.sv
// VRAM write-port arbiter: CPU stores always win, tile blitter fills idle slots.
// Define VRAM_BLIT_COLORKEY_EN to honour blit_key_en (transparent 12'hF0F).
module vram_blitter
   import vram_blit_pkg::*;
#(
   parameter int FB_W = FB_W_DEF,
   parameter int FB_H = FB_H_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_we,
   input  logic [17:0] cpu_addr,
   input  logic [11:0] cpu_data,
   input  logic        blit_start,
   input  logic [1:0]  blit_sel,
   input  logic [8:0]  blit_x,
   input  logic [7:0]  blit_y,
   input  logic [11:0] blit_fill,
   input  logic        blit_key_en,
   input  logic [11:0] bg_data,
   input  logic [11:0] chr_data,
   input  logic [11:0] wall_data,
   output logic [9:0]  rom_addr,
   output logic        blit_busy,
   output logic        blit_done,
   output logic        vram_we,
   output logic [17:0] vram_addr,
   output logic [11:0] vram_data
);
   blit_state_e state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [8:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [11:0] fill_q, fill_d;
   logic        key_q, key_d;
   logic        we_q, we_d;
   logic [17:0] addr_q, addr_d;
   logic [11:0] data_q, data_d;

   logic        clr, adv, issue, keyed, pix_we;
   logic [9:0]  idx;
   logic        last, in_bounds;
   logic [17:0] pix_addr;
   logic [11:0] src_data;

   blit_addr_gen #(
      .FB_W (FB_W),
      .FB_H (FB_H)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .en        (adv),
      .x         (x_q),
      .y         (y_q),
      .idx       (idx),
      .last      (last),
      .in_bounds (in_bounds),
      .pix_addr  (pix_addr)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      x_d     = x_q;
      y_d     = y_q;
      fill_d  = fill_q;
      key_d   = key_q;
      clr     = 1'b0;
      adv     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (blit_start) begin
               state_d = ST_RUN;
               sel_d   = blit_sel;
               x_d     = blit_x;
               y_d     = blit_y;
               fill_d  = blit_fill;
               key_d   = blit_key_en;
               clr     = 1'b1;
            end
         end
         ST_RUN: begin
            if (!cpu_we) begin
               adv = 1'b1;
               if (last)
                  state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      src_data = fill_q;
      unique case (sel_q)
         SRC_BG:   src_data = bg_data;
         SRC_CHR:  src_data = chr_data;
         SRC_WALL: src_data = wall_data;
         SRC_FILL: src_data = fill_q;
         default:  src_data = fill_q;
      endcase
   end

`ifdef VRAM_BLIT_COLORKEY_EN
   assign keyed = key_q && (sel_q != SRC_FILL) && (src_data == COLOR_KEY);
`else
   logic unused_key;
   assign unused_key = key_q;
   assign keyed      = 1'b0;
`endif

   assign issue  = (state_q == ST_RUN) && !cpu_we;
   assign pix_we = issue && in_bounds && !keyed;

   // CPU store takes the slot; the blit pixel simply is not issued this cycle
   always_comb begin
      we_d   = cpu_we || pix_we;
      addr_d = cpu_we ? cpu_addr : pix_addr;
      data_d = cpu_we ? cpu_data : src_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         fill_q  <= '0;
         key_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fill_q  <= fill_d;
         key_q   <= key_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign rom_addr  = (state_q == ST_RUN) ? idx : '0;
   assign blit_busy = (state_q != ST_IDLE);
   assign blit_done = (state_q == ST_DONE);
   assign vram_we   = we_q;
   assign vram_addr = addr_q;
   assign vram_data = data_q;
endmodule
